// File: rtl/echo_msg_pkg.sv
// Shared definitions for the echo request message path: header layout,
// message size and the beat-assembler state encoding.
package echo_msg_pkg;

  localparam int BEAT_W             = 32;
  localparam int HDR_LEN_LSB        = 16;
  localparam int HDR_LEN_W          = 16;
  localparam int HDR_METH_LSB       = 0;
  localparam int HDR_METH_W         = 16;
  localparam int MSG_WORDS_ECHO_SAY = 3;

  typedef enum logic [1:0] {
    HDR     = 2'd0,
    COLLECT = 2'd1,
    DISCARD = 2'd2
  } asm_state_e;

endpackage

// File: rtl/echo_msg_out_buf.sv
// Single-entry holding register between the beat assembler and the
// deserializer; a new message may load in the same cycle the old one drains.
module echo_msg_out_buf #(
  parameter int DATA_W = 96
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_rdy,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;

  // Loading wins over draining so a completing message never sees a bubble.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (r_valid && i_rdy) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/echo_request_beat_assembler.sv
// Collects 32-bit host beats into 3-beat echo request messages, drops and
// counts malformed messages, and hands finished messages to the deserializer.
//
//   state   | meaning
//   HDR     | waiting for a header beat
//   COLLECT | storing body beats of a well-formed message
//   DISCARD | dropping remaining beats of a malformed message
module echo_request_beat_assembler
  import echo_msg_pkg::*;
#(
  parameter int MSG_WORDS = MSG_WORDS_ECHO_SAY,
  parameter int ERR_W     = 16
) (
  input  logic                        CLK,
  input  logic                        nRST,
  input  logic                        beat__ENA,
  input  logic [BEAT_W-1:0]           beat_v,
  output logic                        beat__RDY,
  output logic                        enq__ENA,
  output logic [MSG_WORDS*BEAT_W-1:0] enq_v,
  input  logic                        enq__RDY,
  output logic [ERR_W-1:0]            err_count
);

  localparam int IDX_W = $clog2(MSG_WORDS);
  localparam int MSG_W = MSG_WORDS * BEAT_W;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MSG_WORDS - 1);

  asm_state_e            r_state, w_state_nxt;
  logic [IDX_W-1:0]      r_idx, w_idx_nxt;
  logic [HDR_LEN_W-1:0]  r_rem, w_rem_nxt;
  logic [BEAT_W-1:0]     r_asm [MSG_WORDS-1];
  logic [ERR_W-1:0]      r_err_count;

  logic                  w_xfer;
  logic                  w_last;
  logic                  w_asm_we;
  logic                  w_err_inc;
  logic                  w_load;
  logic                  w_out_valid;
  logic [HDR_LEN_W-1:0]  w_len;
  logic [MSG_W-1:0]      w_msg;

  assign w_len  = beat_v[HDR_LEN_LSB +: HDR_LEN_W];
  assign w_last = (r_state == COLLECT) && (r_idx == IDX_LAST);
  // Only the completing beat waits, and it is released combinationally
  // the cycle the held message drains.
  assign beat__RDY = !(w_last && w_out_valid && !enq__RDY);
  assign w_xfer    = beat__ENA && beat__RDY;

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_rem_nxt   = r_rem;
    w_asm_we    = 1'b0;
    w_err_inc   = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      HDR: begin
        if (w_xfer) begin
          if (w_len == HDR_LEN_W'(MSG_WORDS)) begin
            w_asm_we    = 1'b1;
            w_idx_nxt   = IDX_W'(1);
            w_state_nxt = COLLECT;
          end else if (w_len <= HDR_LEN_W'(1)) begin
            w_err_inc = 1'b1;
          end else begin
            w_err_inc   = 1'b1;
            w_rem_nxt   = w_len - HDR_LEN_W'(2);
            w_state_nxt = DISCARD;
          end
        end
      end
      COLLECT: begin
        if (w_xfer) begin
          if (r_idx == IDX_LAST) begin
            w_load      = 1'b1;
            w_idx_nxt   = '0;
            w_state_nxt = HDR;
          end else begin
            w_asm_we  = 1'b1;
            w_idx_nxt = r_idx + IDX_W'(1);
          end
        end
      end
      DISCARD: begin
        if (w_xfer) begin
          if (r_rem == '0) begin
            w_state_nxt = HDR;
          end else begin
            w_rem_nxt = r_rem - HDR_LEN_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt = HDR;
        w_idx_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state     <= HDR;
      r_idx       <= '0;
      r_rem       <= '0;
      r_err_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_rem   <= w_rem_nxt;
      if (w_err_inc && (r_err_count != '1)) begin
        r_err_count <= r_err_count + ERR_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < MSG_WORDS - 1; i++) begin
        r_asm[i] <= '0;
      end
    end else begin
      for (int i = 0; i < MSG_WORDS - 1; i++) begin
        if (w_asm_we && (r_idx == IDX_W'(i))) begin
          r_asm[i] <= beat_v;
        end
      end
    end
  end

  // The completing beat bypasses the assembly array straight into the buffer.
  always_comb begin
    w_msg = '0;
    for (int i = 0; i < MSG_WORDS - 1; i++) begin
      w_msg[i*BEAT_W +: BEAT_W] = r_asm[i];
    end
    w_msg[(MSG_WORDS-1)*BEAT_W +: BEAT_W] = beat_v;
  end

  echo_msg_out_buf #(
    .DATA_W (MSG_W)
  ) u_out_buf (
    .i_clk   (CLK),
    .i_rst_n (nRST),
    .i_load  (w_load),
    .i_data  (w_msg),
    .i_rdy   (enq__RDY),
    .o_valid (w_out_valid),
    .o_data  (enq_v)
  );

  assign enq__ENA  = w_out_valid;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_echo_request_beat_assembler.sv
// Directed bench for echo_request_beat_assembler with a queue scoreboard
// checked by an independent enq monitor.
module tb_echo_request_beat_assembler;

  logic         CLK = 1'b0;
  logic         nRST;
  logic         beat__ENA;
  logic [31:0]  beat_v;
  logic         beat__RDY;
  logic         enq__ENA;
  logic [95:0]  enq_v;
  logic         enq__RDY;
  logic [15:0]  err_count;

  int           n_vec  = 0;
  int           n_miss = 0;
  int           exp_err = 0;
  logic [95:0]  exp_q [$];

  always #5 CLK = ~CLK;

  echo_request_beat_assembler #(
    .MSG_WORDS (3),
    .ERR_W     (16)
  ) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .beat__ENA (beat__ENA),
    .beat_v    (beat_v),
    .beat__RDY (beat__RDY),
    .enq__ENA  (enq__ENA),
    .enq_v     (enq_v),
    .enq__RDY  (enq__RDY),
    .err_count (err_count)
  );

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every enq transfer must match the oldest expected message.
  always @(negedge CLK) begin
    if (nRST && enq__ENA && enq__RDY) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_miss++;
        $display("FAIL enq_unexpected: got %h expected no message", enq_v);
      end else begin
        logic [95:0] e;
        e = exp_q.pop_front();
        if (enq_v !== e) begin
          n_miss++;
          $display("FAIL enq_data: got %h expected %h", enq_v, e);
        end
      end
    end
  end

  task automatic send(input logic [31:0] d, output int stalls);
    beat__ENA = 1'b1;
    beat_v    = d;
    stalls    = 0;
    @(negedge CLK);
    while (!beat__RDY && stalls < 100) begin
      stalls++;
      @(negedge CLK);
    end
    if (stalls >= 100) begin
      n_vec++;
      n_miss++;
      $display("FAIL beat_timeout: beat %h still stalled after %0d cycles, expected acceptance", d, stalls);
    end
    @(posedge CLK);
    #1;
    beat__ENA = 1'b0;
    beat_v    = 32'hDEAD_BEEF;
  endtask

  task automatic sb(input logic [31:0] d);
    int s;
    send(d, s);
  endtask

  task automatic msg3(input logic [31:0] h, input logic [31:0] m, input logic [31:0] v);
    exp_q.push_back({v, m, h});
    sb(h);
    sb(m);
    sb(v);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int st [6];
    int n1;
    nRST      = 1'b0;
    beat__ENA = 1'b0;
    beat_v    = 32'h0;
    enq__RDY  = 1'b1;
    repeat (3) @(posedge CLK);
    #1 nRST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_enq_ena",   96'(enq__ENA),  96'd0);
    chk("rst_enq_v",     enq_v,          96'd0);
    chk("rst_beat_rdy",  96'(beat__RDY), 96'd1);
    chk("rst_err_count", 96'(err_count), 96'd0);

    // Single message, latency and clear after one transfer
    exp_q.push_back(96'h22222222_11111111_00030007);
    sb(32'h00030007);
    sb(32'h11111111);
    sb(32'h22222222);
    chk("lat_enq_ena", 96'(enq__ENA), 96'd1);
    chk("lat_enq_v",   enq_v,         96'h22222222_11111111_00030007);
    @(posedge CLK); #1;
    chk("lat_enq_clear", 96'(enq__ENA), 96'd0);

    // Back-to-back messages with downstream blocked for 10 cycles
    enq__RDY = 1'b0;
    fork
      begin
        repeat (10) @(posedge CLK);
        #1 enq__RDY = 1'b1;
      end
    join_none
    exp_q.push_back(96'hA2A2A2A2_A1A1A1A1_00030101);
    exp_q.push_back(96'hB2B2B2B2_B1B1B1B1_00030202);
    send(32'h00030101, st[0]);
    send(32'hA1A1A1A1, st[1]);
    send(32'hA2A2A2A2, st[2]);
    send(32'h00030202, st[3]);
    send(32'hB1B1B1B1, st[4]);
    send(32'hB2B2B2B2, st[5]);
    chk("b2b_first5_stalls", 96'(st[0] + st[1] + st[2] + st[3] + st[4]), 96'd0);
    chk("b2b_sixth_stalls",  96'(st[5]), 96'd5);
    chk("b2b_second_ena",    96'(enq__ENA), 96'd1);
    chk("b2b_second_v",      enq_v, 96'hB2B2B2B2_B1B1B1B1_00030202);
    @(posedge CLK); #1;

    // Asynchronous reset mid-cycle while a completing beat is stalled
    enq__RDY = 1'b0;
    sb(32'h00030303);
    sb(32'hC1C1C1C1);
    sb(32'hC2C2C2C2);
    sb(32'h00000000);
    sb(32'h00030404);
    sb(32'hD1D1D1D1);
    beat__ENA = 1'b1;
    beat_v    = 32'hD2D2D2D2;
    @(negedge CLK);
    chk("pre_rst_stall_rdy", 96'(beat__RDY), 96'd0);
    chk("pre_rst_err",       96'(err_count), 96'd1);
    #2;
    nRST = 1'b0;
    exp_q.delete();
    exp_err = 0;
    #1;
    chk("async_rst_enq_ena", 96'(enq__ENA),  96'd0);
    chk("async_rst_enq_v",   enq_v,          96'd0);
    chk("async_rst_rdy",     96'(beat__RDY), 96'd1);
    chk("async_rst_err",     96'(err_count), 96'd0);
    beat__ENA = 1'b0;
    @(negedge CLK);
    nRST     = 1'b1;
    enq__RDY = 1'b1;
    @(posedge CLK); #1;
    msg3(32'h00030505, 32'hE1E1E1E1, 32'hE2E2E2E2);
    @(posedge CLK); #1;

    // Oversized message discarded, then a clean one
    sb(32'h00050001);
    exp_err++;
    sb(32'hF0F0F0F0);
    sb(32'hF1F1F1F1);
    sb(32'h00030000);
    sb(32'hF3F3F3F3);
    chk("discard_err", 96'(err_count), 96'(exp_err));
    chk("discard_no_enq", 96'(enq__ENA), 96'd0);
    msg3(32'h00030005, 32'hAAAAAAAA, 32'hBBBBBBBB);
    @(posedge CLK); #1;

    // Header-only malformed lengths 0 and 1
    sb(32'h00000009);
    sb(32'h00010009);
    exp_err += 2;
    chk("hdr_only_err", 96'(err_count), 96'(exp_err));
    msg3(32'h00030002, 32'h33333333, 32'h44444444);
    @(posedge CLK); #1;

    // Length 2: header plus one dropped beat
    sb(32'h00020077);
    sb(32'h00030077);
    exp_err++;
    msg3(32'h00030008, 32'h55555555, 32'h66666666);
    @(posedge CLK); #1;
    chk("len2_err", 96'(err_count), 96'(exp_err));

    // Saturation of the error counter
    n1 = 16'hFFFE - exp_err;
    for (int i = 0; i < n1; i++) sb(32'h00000000);
    chk("sat_near_err", 96'(err_count), 96'h0FFFE);
    for (int i = 0; i < 65536 - n1; i++) sb(32'h00000000);
    chk("sat_err", 96'(err_count), 96'h0FFFF);
    msg3(32'h00030123, 32'h77777777, 32'h88888888);
    repeat (3) @(posedge CLK);
    #1;
    chk("sat_hold_err", 96'(err_count), 96'h0FFFF);
    chk("queue_empty", 96'(exp_q.size()), 96'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
